input_conditioner: RTL

- Conditions raw board inputs (slide switches, push button) before they reach the CPU debug inputs and the LED display select logic.
- Per-channel 2-FF synchroniser, counter-based debounce, edge pulses.
- The button channel also has a hold/auto-repeat FSM, so a held button can single-step or increment debug values.
- Sits directly upstream of the CPU's dbg_sw_input/dbg_reg_adrs and the LED mux selects; runs on the board clock.

---
 rtl/input_conditioner_pkg.sv | 17 +
 rtl/input_conditioner_if.sv | 24 ++
 rtl/input_conditioner_debounce_channel.sv | 55 +++++
 rtl/input_conditioner.sv | 129 ++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and sizing helpers for the input conditioner.
// Combinational only: no latency, no backpressure.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD_WAIT = 2'd1,
    REPEATING = 2'd2,
    HELD      = 2'd3
  } btn_state_t;

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner.
// Wires only: no latency, no backpressure.
interface input_conditioner_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_in;
  logic             btn_n_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             btn_level;
  logic             btn_press;
  logic             sw_changed;

  modport master (
    output sw_in, btn_n_in,
    input  sw_out, sw_rise, sw_fall, btn_level, btn_press, sw_changed
  );

  modport slave (
    input  sw_in, btn_n_in,
    output sw_out, sw_rise, sw_fall, btn_level, btn_press, sw_changed
  );
endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: 2-FF synchroniser, stability counter, registered edge pulses.
// Level changes DEBOUNCE_CYCLES+2 edges after the raw step; no backpressure.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_nxt,
  output logic fall_nxt
);
  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s;
  logic [CW-1:0] cnt;
  logic          fire;

  // fire is the edge on which level flips; exported so consumers can act on that same edge.
  assign fire     = (s != level) && (cnt == TERM);
  assign rise_nxt = fire && s;
  assign fall_nxt = fire && !s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= RESET_LEVEL;
      s     <= RESET_LEVEL;
      level <= RESET_LEVEL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s    <= s1;
      rise <= rise_nxt;
      fall <= fall_nxt;
      if (s == level || fire) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (fire) begin
        level <= s;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces switches and button; button adds press pulse with hold/auto-repeat.
// Outputs follow raw steps by DEBOUNCE_CYCLES+2 edges; free-running, no backpressure.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input logic                clk,
  input logic                reset_n,
  input_conditioner_if.slave io
);
  localparam int            TMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int            TW        = cnt_width(TMAX);
  localparam logic [TW-1:0] HOLD_TERM = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_TERM  = TW'(REPEAT_CYCLES - 1);

  logic [WIDTH-1:0] sw_out_q;
  logic [WIDTH-1:0] sw_rise_q;
  logic [WIDTH-1:0] sw_fall_q;
  logic [WIDTH-1:0] sw_rise_nxt;
  logic [WIDTH-1:0] sw_fall_nxt;
  logic             sw_changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (1'b0)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (io.sw_in[i]),
      .level   (sw_out_q[i]),
      .rise    (sw_rise_q[i]),
      .fall    (sw_fall_q[i]),
      .rise_nxt(sw_rise_nxt[i]),
      .fall_nxt(sw_fall_nxt[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_changed_q <= 1'b0;
    end else begin
      sw_changed_q <= |(sw_rise_nxt | sw_fall_nxt);
    end
  end

  // The button is debounced in raw (active-low) polarity so its sync stages reset released.
  logic btn_raw_lvl;
  logic btn_raw_rise_unused;
  logic btn_raw_fall_unused;
  logic btn_rise_nxt;
  logic btn_fall_nxt;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b1)
  ) u_btn_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (io.btn_n_in),
    .level   (btn_raw_lvl),
    .rise    (btn_raw_rise_unused),
    .fall    (btn_raw_fall_unused),
    .rise_nxt(btn_fall_nxt),
    .fall_nxt(btn_rise_nxt)
  );

  btn_state_t    state;
  logic [TW-1:0] t;
  logic          btn_press_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RELEASED;
      t           <= '0;
      btn_press_q <= 1'b0;
    end else begin
      btn_press_q <= 1'b0;
      // A release overrides any terminal count reached on the same edge.
      if (btn_fall_nxt) begin
        state <= RELEASED;
        t     <= '0;
      end else begin
        case (state)
          RELEASED: begin
            if (btn_rise_nxt) begin
              btn_press_q <= 1'b1;
              t           <= '0;
              state       <= REPEAT_EN ? HELD_WAIT : HELD;
            end
          end
          HELD_WAIT: begin
            if (t == HOLD_TERM) begin
              btn_press_q <= 1'b1;
              t           <= '0;
              state       <= REPEATING;
            end else begin
              t <= t + TW'(1);
            end
          end
          REPEATING: begin
            if (t == REP_TERM) begin
              btn_press_q <= 1'b1;
              t           <= '0;
            end else begin
              t <= t + TW'(1);
            end
          end
          default: begin
            t <= '0;
          end
        endcase
      end
    end
  end

  assign io.sw_out     = sw_out_q;
  assign io.sw_rise    = sw_rise_q;
  assign io.sw_fall    = sw_fall_q;
  assign io.sw_changed = sw_changed_q;
  assign io.btn_level  = ~btn_raw_lvl;
  assign io.btn_press  = btn_press_q;

endmodule
